// File: rtl/dff_ctrl_pkg.sv
// dff_ctrl_pkg
//   Shared types and helpers for the arbitrated DFF register block.
//   - arb_state_t : arbiter FSM states (IDLE / GRANT / LOCKED)
//   - clog2_min1  : index width that never collapses to zero bits
package dff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Width needed to index n items; at least 1 so n=1/2 still gives a usable vector.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin picker: the first set req at or after ptr wins,
//   wrapping modulo NREQ.
//   Ports:
//     req     in  NREQ   request vector
//     ptr     in  IW     search start index (always < NREQ)
//     win_oh  out NREQ   one-hot winner, zero when no request
//     win_idx out IW     winner index, zero when no request
//     win_vld out 1      any request present
module rr_pick
  import dff_ctrl_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]               req,
  input  logic [clog2_min1(NREQ)-1:0]   ptr,
  output logic [NREQ-1:0]               win_oh,
  output logic [clog2_min1(NREQ)-1:0]   win_idx,
  output logic                          win_vld
);

  localparam int IW = clog2_min1(NREQ);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IW:0]       sum;

  always_comb begin
    // Rotate right by ptr so the search start lands at bit 0.
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NREQ-1:0];
    win_oh  = '0;
    win_vld = |req;
    sum     = '0;
    // Descending scan: the lowest set rotated bit is assigned last and wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) sum = (IW+1)'(k) + {1'b0, ptr};
    end
    if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
    win_idx = sum[IW-1:0];
    if (win_vld) win_oh[win_idx] = 1'b1;
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter
//   One WIDTH-bit register (q/qbar) shared by NREQ requesters. A round-robin
//   arbiter issues registered one-hot grants; the grantee's d loads into q on
//   each edge where it is granted and still requesting. lock lets the owner
//   keep the grant for up to MAX_HOLD consecutive loads.
//   Ports:
//     clk   in  1           rising-edge clock
//     rst   in  1           asynchronous active-low reset
//     req   in  NREQ        write requests
//     lock  in  NREQ        keep-grant requests (only meaningful with req)
//     d     in  NREQ*WIDTH  requester data, d[i*WIDTH +: WIDTH]
//     gnt   out NREQ        registered one-hot grant
//     owner out IW          current grantee index (valid when busy)
//     busy  out 1           any grant active
//     q     out WIDTH       register value
//     qbar  out WIDTH       ~q
module dff_reg_arbiter
  import dff_ctrl_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              lock,
  input  logic [NREQ*WIDTH-1:0]        d,
  output logic [NREQ-1:0]              gnt,
  output logic [clog2_min1(NREQ)-1:0]  owner,
  output logic                         busy,
  output logic [WIDTH-1:0]             q,
  output logic [WIDTH-1:0]             qbar
);

  localparam int IW = clog2_min1(NREQ);
  localparam int HW = clog2_min1(MAX_HOLD);

  arb_state_t        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;

  logic [WIDTH-1:0]  d_arr [NREQ];
  logic              owner_req, owner_lock, rel, arb;
  logic [IW-1:0]     next_ptr, pick_ptr, pick_idx;
  logic [NREQ-1:0]   pick_oh;
  logic              pick_vld;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign d_arr[gi] = d[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign owner_req  = req[owner_q];
  assign owner_lock = lock[owner_q];
  assign next_ptr   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  // Release decision is kept apart from the next-state block so the picker
  // pointer mux does not close a combinational path through one process.
  always_comb begin
    rel = 1'b0;
    case (state_q)
      GRANT:   rel = !owner_req || !(owner_lock && (MAX_HOLD > 1));
      LOCKED:  rel = !owner_req || !owner_lock || (hold_cnt_q == HW'(MAX_HOLD - 1));
      default: rel = 1'b0;
    endcase
  end

  // On release the search already starts past the old owner, so a lone
  // requester is re-granted on the same edge with no idle bubble.
  assign pick_ptr = rel ? next_ptr : ptr_q;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    data_d     = data_q;
    arb        = 1'b0;

    case (state_q)
      GRANT: begin
        if (owner_req) data_d = d_arr[owner_q];
        if (!rel) begin
          state_d    = LOCKED;
          hold_cnt_d = HW'(1);
        end
      end
      LOCKED: begin
        if (owner_req) data_d = d_arr[owner_q];
        if (!rel) hold_cnt_d = hold_cnt_q + 1'b1;
      end
      default: arb = 1'b1;
    endcase

    if (rel) begin
      ptr_d      = next_ptr;
      hold_cnt_d = '0;
      arb        = 1'b1;
    end

    if (arb) begin
      if (pick_vld) begin
        state_d = GRANT;
        gnt_d   = pick_oh;
        owner_d = pick_idx;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        owner_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      data_q     <= data_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = |gnt_q;
  assign q     = data_q;
  assign qbar  = ~data_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// tb_dff_reg_arbiter
//   Directed bench for dff_reg_arbiter (NREQ=4, WIDTH=8, MAX_HOLD=4).
//   Per-cycle invariants run on the falling edge; each scenario task drives
//   inputs just after a rising edge and checks outputs 1 time unit later.
module tb_dff_reg_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] d;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  qbar;

  int n_checks;
  int n_fail;

  dff_reg_arbiter #(.NREQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .lock  (lock),
    .d     (d),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .q     (q),
    .qbar  (qbar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariants plus the load check: the load expected at the coming rising
  // edge is captured on the falling edge before it, then checked one falling
  // edge later.
  logic       exp_load;
  logic [7:0] exp_val;
  initial begin
    exp_load = 1'b0;
    exp_val  = '0;
  end

  always @(negedge clk) begin
    n_checks++;
    if (qbar !== ~q) begin
      n_fail++;
      $display("FAIL inv_qbar: qbar=%h required %h", qbar, ~q);
    end
    n_checks++;
    if (!$onehot0(gnt)) begin
      n_fail++;
      $display("FAIL inv_onehot: gnt=%b required one-hot or zero", gnt);
    end
    if (exp_load && rst) begin
      n_checks++;
      if (q !== exp_val) begin
        n_fail++;
        $display("FAIL inv_load: q=%h required %h", q, exp_val);
      end
    end
    exp_load = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (gnt[i] && req[i]) begin
          exp_load = 1'b1;
          exp_val  = d[i*8 +: 8];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; lock = '0; d = '0;
    cyc(); cyc();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: %b required 0000", gnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b required 0", busy); end
    n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: %h required 00", q); end
    n_checks++; if (qbar !== 8'hFF) begin n_fail++; $display("FAIL reset_qbar: %h required FF", qbar); end
    rst = 1'b1;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b required 0", busy); end
    $display("test_reset: done");
  endtask

  task automatic test_reset_mid();
    d = {8'h00, 8'hA5, 8'h00, 8'h00};
    req = 4'b0100;
    cyc();
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL rmid_gnt1: %b required 0100", gnt); end
    cyc();
    n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL rmid_q: %h required A5", q); end
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL rmid_gnt2: %b required 0100", gnt); end
    rst = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rmid_async_gnt: %b required 0000", gnt); end
    n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL rmid_async_q: %h required 00", q); end
    n_checks++; if (qbar !== 8'hFF) begin n_fail++; $display("FAIL rmid_async_qbar: %h required FF", qbar); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async_busy: %b required 0", busy); end
    // Pointer was 3 before reset; after reset the search from 0 must pick 2 over 3.
    req = 4'b1100;
    cyc();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rmid_held_gnt: %b required 0000", gnt); end
    rst = 1'b1;
    cyc();
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL rmid_ptr0_gnt: %b required 0100", gnt); end
    n_checks++; if (owner !== 2'd2) begin n_fail++; $display("FAIL rmid_ptr0_owner: %0d required 2", owner); end
    cyc();
    n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL rmid_q2: %h required A5", q); end
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL rmid_next_gnt: %b required 1000", gnt); end
    req = 4'b0000;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: busy=%b required 0", busy); end
    n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL rmid_noload: q=%h required A5", q); end
    $display("test_reset_mid: done");
  endtask

  task automatic test_single();
    d = {8'h00, 8'h00, 8'h3C, 8'h00};
    req = 4'b0010;
    cyc();
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL single_gnt1: %b required 0010", gnt); end
    n_checks++; if (owner !== 2'd1) begin n_fail++; $display("FAIL single_owner: %0d required 1", owner); end
    n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL single_q0: %h required A5", q); end
    cyc();
    n_checks++; if (q !== 8'h3C) begin n_fail++; $display("FAIL single_q1: %h required 3C", q); end
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL single_gnt2: %b required 0010", gnt); end
    d = {8'h00, 8'h00, 8'h5A, 8'h00};
    cyc();
    n_checks++; if (q !== 8'h5A) begin n_fail++; $display("FAIL single_q2: %h required 5A", q); end
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL single_gnt3: %b required 0010", gnt); end
    req = 4'b0000;
    cyc();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_release: %b required 0000", gnt); end
    n_checks++; if (q !== 8'h5A) begin n_fail++; $display("FAIL single_hold_q: %h required 5A", q); end
    $display("test_single: done");
  endtask

  // Pointer is 2 here; owner 3 is released with req=1100 so the pointer wraps to 0.
  task automatic test_wrap();
    d = {8'hC3, 8'h24, 8'h5A, 8'h11};
    req = 4'b1000;
    cyc();
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_gnt3: %b required 1000", gnt); end
    n_checks++; if (owner !== 2'd3) begin n_fail++; $display("FAIL wrap_owner3: %0d required 3", owner); end
    req = 4'b1100;
    cyc();
    n_checks++; if (q !== 8'hC3) begin n_fail++; $display("FAIL wrap_q: %h required C3", q); end
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL wrap_gnt2: %b required 0100", gnt); end
    $display("test_wrap: done");
  endtask

  task automatic test_drop();
    req = 4'b1000;
    cyc();
    n_checks++; if (q !== 8'hC3) begin n_fail++; $display("FAIL drop_q: %h required C3", q); end
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL drop_move: %b required 1000", gnt); end
    req = 4'b0000;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: busy=%b required 0", busy); end
    n_checks++; if (q !== 8'hC3) begin n_fail++; $display("FAIL drop_q2: %h required C3", q); end
    $display("test_drop: done");
  endtask

  task automatic test_round_robin();
    logic [7:0] rr_val [4];
    logic [3:0] exp_g;
    logic [7:0] exp_q;
    rr_val[0] = 8'h11; rr_val[1] = 8'h22; rr_val[2] = 8'h33; rr_val[3] = 8'h44;
    d = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      exp_g = 4'b0001 << ((k - 1) % 4);
      exp_q = (k == 1) ? 8'hC3 : rr_val[(k - 2) % 4];
      $display("rr step %0d: gnt=%b q=%h", k, gnt, q);
      n_checks++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt[%0d]: %b required %b", k, gnt, exp_g); end
      n_checks++; if (q !== exp_q) begin n_fail++; $display("FAIL rr_q[%0d]: %h required %h", k, q, exp_q); end
    end
    req = 4'b0000;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle: busy=%b required 0", busy); end
    n_checks++; if (q !== 8'h33) begin n_fail++; $display("FAIL rr_final_q: %h required 33", q); end
  endtask

  task automatic test_lock_limit();
    d = {8'hD3, 8'h00, 8'h00, 8'hA0};
    req = 4'b1001; lock = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      d[7:0] = 8'hA0 + 8'(k);
      cyc();
      $display("lock step %0d: gnt=%b q=%h", k, gnt, q);
      if (k <= 4) begin
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL lock_hold[%0d]: %b required 0001", k, gnt); end
      end else begin
        n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL lock_limit: %b required 1000", gnt); end
        n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL lock_q: %h required A5", q); end
      end
    end
    req = 4'b0000; lock = 4'b0000;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lock_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_lock_drop();
    req = 4'b1001; lock = 4'b0001;
    cyc();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL ldrop_gnt1: %b required 0001", gnt); end
    cyc();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL ldrop_gnt2: %b required 0001", gnt); end
    lock = 4'b0000;
    cyc();
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL ldrop_release: %b required 1000", gnt); end
    req = 4'b0000;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ldrop_idle: busy=%b required 0", busy); end
    $display("test_lock_drop: done");
  endtask

  task automatic test_reset_mid_lock();
    req = 4'b1001; lock = 4'b0001;
    cyc(); cyc(); cyc();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rlock_pre: %b required 0001", gnt); end
    rst = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rlock_gnt: %b required 0000", gnt); end
    n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL rlock_q: %h required 00", q); end
    cyc();
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k <= 4) begin
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rlock_hold[%0d]: %b required 0001", k, gnt); end
      end else begin
        n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL rlock_limit: %b required 1000", gnt); end
      end
    end
    req = 4'b0000; lock = 4'b0000;
    cyc();
    $display("test_reset_mid_lock: done");
  endtask

  // lock[0] without req[0] must not pull the grant to requester 0.
  task automatic test_lock_no_req();
    req = 4'b0010; lock = 4'b0001;
    cyc();
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL lnr_gnt1: %b required 0010", gnt); end
    cyc();
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL lnr_gnt2: %b required 0010", gnt); end
    req = 4'b0000; lock = 4'b0000;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lnr_idle: busy=%b required 0", busy); end
    $display("test_lock_no_req: done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b0;
    req  = '0;
    lock = '0;
    d    = '0;
    test_reset();
    test_reset_mid();
    test_single();
    test_wrap();
    test_drop();
    test_round_robin();
    test_lock_limit();
    test_lock_drop();
    test_reset_mid_lock();
    test_lock_no_req();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
